// File: rtl/ball_game_pkg.sv
// Shared definitions for the ball game sequencer: FSM state encodings, playfield
// limits, default lives and a saturating score increment.
package ball_game_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RUN     = 3'd1;
  localparam logic [2:0] ST_PAUSE   = 3'd2;
  localparam logic [2:0] ST_RESPAWN = 3'd3;
  localparam logic [2:0] ST_OVER    = 3'd4;

  localparam int FIELD_X_MAX   = 639;
  localparam int FIELD_Y_MAX   = 479;
  localparam int LIVES_DEFAULT = 3;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ball_tick_gen.sv
// Ball step divider: counts 0..TICK_DIV-1 and flags the edge on which the count
// lands on TICK_DIV-1. clear_i forces the count to 0, hold_i freezes it.
module ball_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic hold_i,
  output logic tick_o
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (!hold_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
    end
  end

  // Asserted when the next count reads LAST, so a registered copy lines up with it.
  assign tick_o = !clear_i && !hold_i && (count_d == LAST);

  // NOTE: state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ball_game_ctrl.sv
// Ball game sequencer: step strobes, move gating, out-of-field detection, score,
// lives and game-over. Optional pause support is enabled by BALL_CTRL_PAUSE_EN.
module ball_game_ctrl
  import ball_game_pkg::*;
#(
  parameter int TICK_DIV = 4,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = FIELD_Y_MAX,
  parameter int LIVES    = LIVES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pause_btn,
  input  logic        left_in,
  input  logic        right_in,
  input  logic [15:0] y_ball,
  output logic        ball_reset,
  output logic        step_en,
  output logic        left,
  output logic        right,
  output logic [2:0]  state,
  output logic [15:0] score,
  output logic [1:0]  lives,
  output logic        game_over
);

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);

  logic [2:0]  state_q, state_d;
  logic [15:0] score_q, score_d;
  logic [1:0]  lives_q, lives_d;
  logic        ball_reset_q, ball_reset_d;
  logic        step_en_q, step_en_d;
  logic        left_q, left_d;
  logic        right_q, right_d;
  logic        game_over_q, game_over_d;

  logic in_run, out_of_field, tick, tick_clear, tick_hold;

  assign in_run       = (state_q == ST_RUN);
  assign out_of_field = in_run && ((int'(y_ball) < Y_MIN) || (int'(y_ball) > Y_MAX));

`ifdef BALL_CTRL_PAUSE_EN
  assign tick_hold = (state_q == ST_PAUSE) || (in_run && !out_of_field && pause_btn);
`else
  logic unused_pause;
  assign unused_pause = pause_btn;
  assign tick_hold    = 1'b0;
`endif

  // A life loss restarts the step phase, as does every entry into RUN.
  assign tick_clear = !(in_run || (state_q == ST_PAUSE)) || out_of_field;

  ball_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .clear_i (tick_clear),
    .hold_i  (tick_hold),
    .tick_o  (tick)
  );

  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    lives_d      = lives_q;
    ball_reset_d = 1'b0;
    step_en_d    = 1'b0;
    left_d       = 1'b0;
    right_d      = 1'b0;
    game_over_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ball_reset_d = 1'b1;
        if (start) begin
          state_d      = ST_RUN;
          ball_reset_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (out_of_field) begin
          if (lives_q > 2'd1) begin
            lives_d      = lives_q - 2'd1;
            state_d      = ST_RESPAWN;
            ball_reset_d = 1'b1;
          end else begin
            lives_d     = 2'd0;
            state_d     = ST_OVER;
            game_over_d = 1'b1;
          end
        end
`ifdef BALL_CTRL_PAUSE_EN
        else if (pause_btn) begin
          state_d = ST_PAUSE;
        end
`endif
        else if (tick) begin
          step_en_d = 1'b1;
          left_d    = left_in & ~right_in;
          right_d   = right_in & ~left_in;
          score_d   = sat_inc16(score_q);
        end
      end
`ifdef BALL_CTRL_PAUSE_EN
      ST_PAUSE: begin
        if (pause_btn) begin
          state_d = ST_RUN;
        end
      end
`endif
      ST_RESPAWN: begin
        state_d = ST_RUN;
      end
      ST_OVER: begin
        game_over_d = 1'b1;
        if (start) begin
          state_d      = ST_IDLE;
          score_d      = 16'd0;
          lives_d      = LIVES_INIT;
          game_over_d  = 1'b0;
          ball_reset_d = 1'b1;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        ball_reset_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      score_q      <= 16'd0;
      lives_q      <= LIVES_INIT;
      ball_reset_q <= 1'b1;
      step_en_q    <= 1'b0;
      left_q       <= 1'b0;
      right_q      <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      ball_reset_q <= ball_reset_d;
      step_en_q    <= step_en_d;
      left_q       <= left_d;
      right_q      <= right_d;
      game_over_q  <= game_over_d;
    end
  end

  assign state      = state_q;
  assign score      = score_q;
  assign lives      = lives_q;
  assign ball_reset = ball_reset_q;
  assign step_en    = step_en_q;
  assign left       = left_q;
  assign right      = right_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_ball_game_ctrl.sv
// Self-checking bench for ball_game_ctrl (default build, pause disabled): directed
// scenarios plus randomized play against a cycle-level game model.
module tb_ball_game_ctrl;

  localparam int TICK_DIV = 4;
  localparam int Y_MAX    = 479;
  localparam int LIVES    = 3;

  logic        clk = 1'b0;
  logic        reset, start, pause_btn, left_in, right_in;
  logic [15:0] y_ball;
  logic        ball_reset, step_en, left, right, game_over;
  logic [2:0]  state;
  logic [15:0] score;
  logic [1:0]  lives;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ball_game_ctrl #(
    .TICK_DIV (TICK_DIV),
    .Y_MIN    (0),
    .Y_MAX    (Y_MAX),
    .LIVES    (LIVES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pause_btn  (pause_btn),
    .left_in    (left_in),
    .right_in   (right_in),
    .y_ball     (y_ball),
    .ball_reset (ball_reset),
    .step_en    (step_en),
    .left       (left),
    .right      (right),
    .state      (state),
    .score      (score),
    .lives      (lives),
    .game_over  (game_over)
  );

  // Game model: mode 0 idle, 1 playing, 3 respawning, 4 over; m_run counts edges since play (re)started.
  int   m_state = 0;
  int   m_score = 0;
  int   m_lives = LIVES;
  int   m_run   = 0;
  logic e_br    = 1'b1;
  logic e_step  = 1'b0;
  logic e_left  = 1'b0;
  logic e_right = 1'b0;

  logic [24:0] obs;
  assign obs = {state, ball_reset, step_en, left, right, score, lives, game_over};

  function automatic logic [24:0] exp_vec();
    return {3'(m_state), e_br, e_step, e_left, e_right, 16'(m_score), 2'(m_lives), (m_state == 4)};
  endfunction

  task automatic model_edge(input logic r, input logic s, input logic li, input logic ri,
                            input logic [15:0] y);
    e_step  = 1'b0;
    e_left  = 1'b0;
    e_right = 1'b0;
    if (r) begin
      m_state = 0; m_score = 0; m_lives = LIVES; e_br = 1'b1;
    end else begin
      case (m_state)
        0: begin
          e_br = !s;
          if (s) begin m_state = 1; m_run = 0; end
        end
        1: begin
          if (int'(y) > Y_MAX) begin
            m_lives = m_lives - 1;
            m_state = (m_lives == 0) ? 4 : 3;
            e_br    = (m_lives != 0);
          end else begin
            e_br  = 1'b0;
            m_run = m_run + 1;
            if (m_run % TICK_DIV == TICK_DIV - 1) begin
              e_step  = 1'b1;
              e_left  = li && !ri;
              e_right = ri && !li;
              if (m_score < 65535) m_score = m_score + 1;
            end
          end
        end
        3: begin m_state = 1; m_run = 0; e_br = 1'b0; end
        4: begin
          e_br = s;
          if (s) begin m_state = 0; m_score = 0; m_lives = LIVES; end
        end
        default: m_state = 0;
      endcase
    end
  endtask

  // Applies inputs, takes one edge, advances the model, leaves time 1 unit past the edge.
  task automatic cyc(input logic r, input logic s, input logic p, input logic li,
                     input logic ri, input logic [15:0] y);
    reset = r; start = s; pause_btn = p; left_in = li; right_in = ri; y_ball = y;
    @(posedge clk);
    model_edge(r, s, li, ri, y);
    #1;
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0, 0, 16'd100);
    cyc(1, 1, 1, 1, 0, 16'd999);
    n_checks++;
    if (obs !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 2'd3, 1'b0}) begin
      n_fail++; $display("FAIL reset_values: got %h want %h", obs, {3'd0, 4'b1000, 16'd0, 2'd3, 1'b0});
    end
    cyc(0, 0, 0, 0, 0, 16'd100);
    n_checks++;
    if (obs !== exp_vec() || state !== 3'd0 || ball_reset !== 1'b1) begin
      n_fail++; $display("FAIL idle_hold: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_start_latency();
    int steps = 0;
    cyc(0, 1, 0, 0, 0, 16'd100);
    n_checks++;
    if (state !== 3'd1 || ball_reset !== 1'b0 || step_en !== 1'b0) begin
      n_fail++; $display("FAIL start_run: got state %0d br %b step %b want 1 0 0", state, ball_reset, step_en);
    end
    for (int k = 1; k <= 3 * TICK_DIV; k++) begin
      cyc(0, 1, 0, 0, 0, 16'd200);
      n_checks++;
      if (step_en !== ((k % TICK_DIV) == TICK_DIV - 1) || obs !== exp_vec()) begin
        n_fail++; $display("FAIL step_phase_%0d: got %h want %h", k, obs, exp_vec());
      end
      if (step_en === 1'b1) steps++;
    end
    n_checks++;
    if (score !== 16'd3 || steps != 3) begin
      n_fail++; $display("FAIL step_score: got score %0d steps %0d want 3 3", score, steps);
    end
  endtask

  task automatic test_steering();
    int nl = 0;
    for (int k = 0; k < 2 * TICK_DIV; k++) begin
      cyc(0, 0, 0, 1, 0, 16'd300);
      n_checks++;
      if (left !== step_en || right !== 1'b0 || obs !== exp_vec()) begin
        n_fail++; $display("FAIL left_strobe: got l %b r %b step %b want l=step r=0", left, right, step_en);
      end
      if (left === 1'b1) nl++;
    end
    n_checks++;
    if (nl != 2) begin
      n_fail++; $display("FAIL left_count: got %0d want 2", nl);
    end
    for (int k = 0; k < 2 * TICK_DIV; k++) begin
      cyc(0, 0, 0, 1, 1, 16'd300);
      n_checks++;
      if ((left | right) !== 1'b0 || obs !== exp_vec()) begin
        n_fail++; $display("FAIL both_pressed: got l %b r %b want 0 0", left, right);
      end
    end
    for (int k = 0; k < TICK_DIV; k++) begin
      cyc(0, 0, 0, 0, 1, 16'd300);
      n_checks++;
      if (right !== step_en || left !== 1'b0 || obs !== exp_vec()) begin
        n_fail++; $display("FAIL right_strobe: got l %b r %b step %b", left, right, step_en);
      end
    end
  endtask

  task automatic test_life_loss();
    logic [15:0] kept;
    cyc(0, 0, 0, 0, 0, 16'd479);
    n_checks++;
    if (state !== 3'd1 || lives !== 2'd3) begin
      n_fail++; $display("FAIL edge_479_in_field: got state %0d lives %0d want 1 3", state, lives);
    end
    kept = score;
    cyc(0, 0, 0, 0, 0, 16'd480);
    n_checks++;
    if (obs !== {3'd3, 1'b1, 3'b000, kept, 2'd2, 1'b0} || obs !== exp_vec()) begin
      n_fail++; $display("FAIL fall_480: got %h want %h", obs, {3'd3, 4'b1000, kept, 2'd2, 1'b0});
    end
    cyc(0, 0, 0, 0, 0, 16'd240);
    n_checks++;
    if (state !== 3'd1 || ball_reset !== 1'b0 || score !== kept || obs !== exp_vec()) begin
      n_fail++; $display("FAIL respawn_one_cycle: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_game_over();
    cyc(0, 0, 0, 0, 0, 16'hFFFF);
    cyc(0, 0, 0, 0, 0, 16'd240);
    cyc(0, 0, 0, 0, 0, 16'd480);
    n_checks++;
    if (state !== 3'd4 || game_over !== 1'b1 || lives !== 2'd0 || ball_reset !== 1'b0
        || obs !== exp_vec()) begin
      n_fail++; $display("FAIL game_over_entry: got %h want %h", obs, exp_vec());
    end
    for (int k = 0; k < 2 * TICK_DIV; k++) begin
      cyc(0, 0, 0, 1, 0, 16'd480);
      n_checks++;
      if (step_en !== 1'b0 || state !== 3'd4 || obs !== exp_vec()) begin
        n_fail++; $display("FAIL over_frozen: got %h want %h", obs, exp_vec());
      end
    end
    cyc(0, 1, 0, 0, 0, 16'd480);
    n_checks++;
    if (obs !== {3'd0, 1'b1, 3'b000, 16'd0, 2'd3, 1'b0} || obs !== exp_vec()) begin
      n_fail++; $display("FAIL restart_idle: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_score_saturation();
    int steps = 0;
    cyc(0, 1, 0, 0, 0, 16'd100);
    force dut.score_q = 16'hFFFE;
    #1;
    release dut.score_q;
    m_score = 16'hFFFE;
    for (int k = 0; k < 2 * TICK_DIV; k++) begin
      cyc(0, 0, 0, 0, 0, 16'd100);
      if (step_en === 1'b1) begin
        steps++;
        n_checks++;
        if (score !== 16'hFFFF) begin
          n_fail++; $display("FAIL score_saturate_%0d: got %h want ffff", steps, score);
        end
      end
    end
    n_checks++;
    if (steps != 2 || obs !== exp_vec()) begin
      n_fail++; $display("FAIL saturate_steps: got %0d steps vec %h want 2 %h", steps, obs, exp_vec());
    end
  endtask

  task automatic test_reset_mid_run();
    cyc(0, 0, 0, 1, 0, 16'd100);
    cyc(1, 0, 0, 1, 0, 16'd100);
    n_checks++;
    if (obs !== {3'd0, 1'b1, 3'b000, 16'd0, 2'd3, 1'b0}) begin
      n_fail++; $display("FAIL reset_mid_run: got %h want %h", obs, {3'd0, 4'b1000, 16'd0, 2'd3, 1'b0});
    end
    cyc(0, 1, 0, 0, 0, 16'd100);
    for (int k = 1; k <= TICK_DIV; k++) begin
      cyc(0, 0, 0, 0, 0, 16'd100);
      n_checks++;
      if (step_en !== (k == TICK_DIV - 1) || obs !== exp_vec()) begin
        n_fail++; $display("FAIL post_reset_phase_%0d: got %h want %h", k, obs, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    int r;
    logic [15:0] y;
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 39);
      y = (r == 0) ? 16'd480 : (r == 1) ? 16'($urandom_range(481, 65535)) : 16'($urandom_range(0, 479));
      cyc(($urandom_range(0, 149) == 0), ($urandom_range(0, 7) == 0), 1'($urandom),
          1'($urandom), 1'($urandom), y);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL random_%0d: got %h want %h", k, obs, exp_vec());
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pause_btn = 1'b0; left_in = 1'b0; right_in = 1'b0; y_ball = 16'd100;
    test_reset();
    test_start_latency();
    test_steering();
    test_life_loss();
    test_game_over();
    test_score_saturation();
    test_reset_mid_run();
    cyc(1, 0, 0, 0, 0, 16'd100);
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
